// File: rtl/pool_scheduler.sv
// Round-robin scheduler that locks one max-pool engine to a channel for a whole frame (feed, then drain).
// One cycle of grant overhead per frame; beat paths are combinational, so stalls pass straight through valid/ready.
package mnist_pkg;
  typedef logic [15:0] feature_type;
  localparam int FW = $bits(feature_type);
endpackage

module pool_scheduler
  import mnist_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int IMAGE_HEIGHT = 28,
  parameter int IMAGE_WIDTH  = 28,
  parameter int ROW_STRIDE   = 2,
  parameter int COL_STRIDE   = 2
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_CH-1:0]         in_valid,
  output logic [NUM_CH-1:0]         in_ready,
  input  logic [NUM_CH*FW-1:0]      in_data,
  output logic                      eng_in_valid,
  input  logic                      eng_in_ready,
  output logic [FW-1:0]             eng_in_data,
  input  logic                      eng_out_valid,
  output logic                      eng_out_ready,
  input  logic [FW-1:0]             eng_out_data,
  output logic [NUM_CH-1:0]         out_valid,
  input  logic [NUM_CH-1:0]         out_ready,
  output logic [FW-1:0]             out_data,
  output logic [$clog2(NUM_CH)-1:0] grant,
  output logic                      busy,
  output logic                      proto_err,
  output logic [15:0]               frames_done
);

  localparam int IN_BEATS  = IMAGE_HEIGHT * IMAGE_WIDTH;
  localparam int OUT_BEATS = (IMAGE_HEIGHT / ROW_STRIDE) * (IMAGE_WIDTH / COL_STRIDE);
  localparam int GW        = $clog2(NUM_CH);
  localparam int ICW       = $clog2(IN_BEATS);
  localparam int OCW       = $clog2(OUT_BEATS);

  typedef enum logic [1:0] {IDLE, FEED, DRAIN} state_t;

  state_t         state;
  logic [GW-1:0]  rr_ptr;
  logic [ICW-1:0] in_cnt;
  logic [OCW-1:0] out_cnt;
  logic           pick_vld;
  logic [GW-1:0]  pick_idx;
  logic [GW-1:0]  next_ptr;
  logic           in_xfer;
  logic           out_xfer;

  // Walk downward so the lowest offset from rr_ptr overwrites any later candidate.
  always_comb begin
    int cand;
    cand     = 0;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_CH) cand = cand - NUM_CH;
      if (in_valid[cand]) begin
        pick_vld = 1'b1;
        pick_idx = GW'(cand);
      end
    end
  end

  assign next_ptr = (grant == GW'(NUM_CH - 1)) ? '0 : grant + GW'(1);

  // Data buses are zeroed outside their owning state so an idle block drives all-zero outputs.
  always_comb begin
    in_ready      = '0;
    eng_in_valid  = 1'b0;
    eng_in_data   = '0;
    out_valid     = '0;
    eng_out_ready = 1'b0;
    out_data      = '0;
    case (state)
      FEED: begin
        eng_in_valid    = in_valid[grant];
        eng_in_data     = in_data[int'(grant)*FW +: FW];
        in_ready[grant] = eng_in_ready;
      end
      DRAIN: begin
        out_valid[grant] = eng_out_valid;
        eng_out_ready    = out_ready[grant];
        out_data         = eng_out_data;
      end
      default: ;
    endcase
  end

  assign in_xfer  = eng_in_valid & eng_in_ready;
  assign out_xfer = eng_out_valid & eng_out_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      grant       <= '0;
      rr_ptr      <= '0;
      in_cnt      <= '0;
      out_cnt     <= '0;
      busy        <= 1'b0;
      proto_err   <= 1'b0;
      frames_done <= '0;
    end else begin
      if (eng_out_valid && state != DRAIN) proto_err <= 1'b1;
      case (state)
        IDLE: begin
          if (pick_vld) begin
            grant  <= pick_idx;
            in_cnt <= '0;
            busy   <= 1'b1;
            state  <= FEED;
          end
        end
        FEED: begin
          if (in_xfer) begin
            in_cnt <= in_cnt + ICW'(1);
            if (in_cnt == ICW'(IN_BEATS - 1)) begin
              out_cnt <= '0;
              state   <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (out_xfer) begin
            out_cnt <= out_cnt + OCW'(1);
            if (out_cnt == OCW'(OUT_BEATS - 1)) begin
              rr_ptr      <= next_ptr;
              frames_done <= frames_done + 16'd1;
              busy        <= 1'b0;
              state       <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pool_scheduler.sv
// Bench for pool_scheduler: channel producers, a behavioural 2x2 max-pool engine, and a pooled-output scoreboard.
module tb_pool_scheduler;
  import mnist_pkg::*;

  localparam int NUM_CH    = 4;
  localparam int H         = 28;
  localparam int W         = 28;
  localparam int IN_BEATS  = H * W;
  localparam int OUT_BEATS = (H / 2) * (W / 2);

  logic                   clock = 1'b0;
  logic                   reset_n = 1'b0;
  logic [NUM_CH-1:0]      in_valid, in_ready, out_valid, out_ready;
  logic [NUM_CH*FW-1:0]   in_data;
  logic                   eng_in_valid, eng_in_ready, eng_out_valid, eng_out_ready;
  logic [FW-1:0]          eng_in_data, eng_out_data, out_data;
  logic [1:0]             grant;
  logic                   busy, proto_err;
  logic [15:0]            frames_done;

  always #5 clock = ~clock;

  pool_scheduler #(.NUM_CH(NUM_CH), .IMAGE_HEIGHT(H), .IMAGE_WIDTH(W),
                   .ROW_STRIDE(2), .COL_STRIDE(2)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .eng_in_valid(eng_in_valid), .eng_in_ready(eng_in_ready), .eng_in_data(eng_in_data),
    .eng_out_valid(eng_out_valid), .eng_out_ready(eng_out_ready), .eng_out_data(eng_out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .grant(grant), .busy(busy), .proto_err(proto_err), .frames_done(frames_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scenario controls (written by the main sequence) and bench models.
  int pn[NUM_CH] = '{default: 0};
  int pf[NUM_CH] = '{default: 0};
  int pb[NUM_CH] = '{default: 0};
  bit bp = 1'b0, vdrop = 1'b0, force_ev = 1'b0;
  int gq[$];
  int exp_ch[$];
  logic [FW-1:0] exp_dat[$];
  logic [FW-1:0] img [IN_BEATS];

  function automatic logic [FW-1:0] gen(int c, int f, int b);
    logic [31:0] x;
    x = 32'(b * 40503 + c * 7919 + f * 104729 + 12345);
    x = x ^ (x >> 13) ^ (x << 5);
    return x[FW-1:0];
  endfunction

  function automatic logic [FW-1:0] pool_img(int k);
    logic [FW-1:0] m;
    int r, q;
    r = k / (W / 2);
    q = k % (W / 2);
    m = '0;
    for (int dr = 0; dr < 2; dr++)
      for (int dc = 0; dc < 2; dc++)
        if (img[(2*r+dr)*W + 2*q+dc] > m) m = img[(2*r+dr)*W + 2*q+dc];
    return m;
  endfunction

  task automatic push_expected(int c, int f);
    logic [FW-1:0] m, v;
    for (int r = 0; r < H/2; r++)
      for (int q = 0; q < W/2; q++) begin
        m = '0;
        for (int dr = 0; dr < 2; dr++)
          for (int dc = 0; dc < 2; dc++) begin
            v = gen(c, f, (2*r+dr)*W + 2*q+dc);
            if (v > m) m = v;
          end
        exp_ch.push_back(c);
        exp_dat.push_back(m);
      end
  endtask

  // Observe at negedge, advance models and drive at posedge+1.
  initial begin : driver
    logic [NUM_CH-1:0] in_hs;
    logic ein_hs, eout_hs, busy_prev;
    logic [FW-1:0] ein_dat;
    int fr_in, fr_out, stray, cnt_mis, e_in_cnt, e_lat, e_idx;
    bit e_pend, e_act;
    in_valid = '0; in_data = '0; eng_in_ready = 1'b0; eng_out_valid = 1'b0;
    eng_out_data = '0; out_ready = '0;
    busy_prev = 1'b0; fr_in = 0; fr_out = 0; stray = 0; cnt_mis = 0;
    e_in_cnt = 0; e_lat = 0; e_idx = 0; e_pend = 0; e_act = 0;
    forever begin
      @(negedge clock);
      in_hs = '0; ein_hs = 1'b0; eout_hs = 1'b0; ein_dat = '0;
      if (reset_n) begin
        in_hs   = in_valid & in_ready;
        ein_hs  = eng_in_valid & eng_in_ready;
        eout_hs = eng_out_valid & eng_out_ready;
        ein_dat = eng_in_data;
        if (busy && !busy_prev) begin
          fr_in = 0; fr_out = 0; stray = 0; cnt_mis = 0;
          chk("grant_expected", 32'(gq.size() > 0), 1);
          if (gq.size() > 0) chk("grant", 32'(grant), 32'(gq.pop_front()));
        end
        if (busy) begin
          if (fr_in < IN_BEATS) begin
            if (int'(dut.in_cnt) != fr_in) cnt_mis++;
          end else if (int'(dut.out_cnt) != fr_out) cnt_mis++;
          if ((in_ready & ~(NUM_CH'(1) << grant)) != '0 ||
              (out_valid & ~(NUM_CH'(1) << grant)) != '0) stray++;
        end
        for (int c = 0; c < NUM_CH; c++)
          if (out_valid[c] && out_ready[c]) begin
            if (exp_ch.size() == 0) chk("out_unexpected", 32'(exp_ch.size()), 1);
            else begin
              chk("out_ch", 32'(c), 32'(exp_ch.pop_front()));
              chk("out_dat", 32'(out_data), 32'(exp_dat.pop_front()));
            end
          end
        fr_in  += int'(ein_hs);
        fr_out += int'(eout_hs);
        if (!busy && busy_prev) begin
          chk("frame_in_beats", 32'(fr_in), IN_BEATS);
          chk("frame_out_beats", 32'(fr_out), OUT_BEATS);
          chk("stray_channel", 32'(stray), 0);
          chk("cnt_tracks_hs", 32'(cnt_mis), 0);
        end
        busy_prev = busy;
      end
      @(posedge clock); #1;
      if (!reset_n) begin
        for (int c = 0; c < NUM_CH; c++) pb[c] = 0;
        e_in_cnt = 0; e_lat = 0; e_idx = 0; e_pend = 0; e_act = 0;
        exp_ch.delete(); exp_dat.delete();
        busy_prev = 1'b0; fr_in = 0; fr_out = 0;
      end else begin
        for (int c = 0; c < NUM_CH; c++)
          if (in_hs[c]) begin
            pb[c]++;
            if (pb[c] == IN_BEATS) begin
              push_expected(c, pf[c]);
              pf[c]++; pb[c] = 0; pn[c]--;
            end
          end
        if (ein_hs) begin
          img[e_in_cnt] = ein_dat;
          e_in_cnt++;
          if (e_in_cnt == IN_BEATS) begin e_in_cnt = 0; e_lat = 3; e_pend = 1; end
        end
        if (eout_hs) begin
          e_idx++;
          if (e_idx == OUT_BEATS) e_act = 0;
        end
        if (e_pend) begin
          if (e_lat == 0) begin e_pend = 0; e_act = 1; e_idx = 0; end
          else e_lat--;
        end
      end
      for (int c = 0; c < NUM_CH; c++) begin
        in_valid[c] = (pn[c] > 0) && (!vdrop || $urandom_range(0, 1) == 1);
        in_data[c*FW +: FW] = gen(c, pf[c], pb[c]);
      end
      eng_in_ready  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready     = bp ? NUM_CH'($urandom_range(0, 15)) : '1;
      eng_out_valid = e_act | force_ev;
      eng_out_data  = e_act ? pool_img(e_idx) : '0;
    end
  end

  task automatic wait_done(input int n, input int budget, input string tag);
    int cyc = 0;
    while (frames_done != 16'(n) && cyc < budget) begin @(negedge clock); cyc++; end
    chk(tag, 32'(frames_done), 32'(n));
    @(negedge clock);
  endtask

  task automatic check_reset_outputs(input string p);
    chk({p, "_busy"}, 32'(busy), 0);
    chk({p, "_grant"}, 32'(grant), 0);
    chk({p, "_state"}, 32'(int'(dut.state)), 0);
    chk({p, "_in_ready"}, 32'(in_ready), 0);
    chk({p, "_eng_in_valid"}, 32'(eng_in_valid), 0);
    chk({p, "_eng_in_data"}, 32'(eng_in_data), 0);
    chk({p, "_eng_out_ready"}, 32'(eng_out_ready), 0);
    chk({p, "_out_valid"}, 32'(out_valid), 0);
    chk({p, "_out_data"}, 32'(out_data), 0);
    chk({p, "_proto_err"}, 32'(proto_err), 0);
    chk({p, "_frames_done"}, 32'(frames_done), 0);
  endtask

  initial begin : main
    int cyc;
    repeat (2) @(negedge clock);
    #1 check_reset_outputs("rst");

    // Single channel: ch2 alone.
    pn[2] = 1; gq.push_back(2);
    @(negedge clock); reset_n = 1'b1;
    wait_done(1, 5000, "single_done");
    chk("single_rr_ptr", 32'(dut.rr_ptr), 3);
    chk("single_proto", 32'(proto_err), 0);
    chk("single_sb_empty", 32'(exp_ch.size()), 0);

    // Wrap: ch3 served, then ch3 and ch0 both requesting -> 0 then 3.
    pn[3] = 2; pn[0] = 1;
    gq.push_back(3); gq.push_back(0); gq.push_back(3);
    wait_done(4, 8000, "wrap_done");
    chk("wrap_gq_empty", 32'(gq.size()), 0);

    // Contention from reset: ch0, ch1, ch3.
    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    pn[0] = 2; pn[1] = 1; pn[3] = 1;
    gq.push_back(0); gq.push_back(1); gq.push_back(3); gq.push_back(0);
    @(negedge clock); reset_n = 1'b1;
    wait_done(4, 8000, "contention_done");
    chk("contention_gq_empty", 32'(gq.size()), 0);
    chk("contention_rr_ptr", 32'(dut.rr_ptr), 1);

    // Backpressure on both sides plus valid drops mid-frame.
    bp = 1'b1; vdrop = 1'b1;
    pn[1] = 2; gq.push_back(1); gq.push_back(1);
    wait_done(6, 30000, "backpressure_done");
    bp = 1'b0; vdrop = 1'b0;
    chk("bp_sb_empty", 32'(exp_ch.size()), 0);

    // Protocol error: engine output strobed during FEED.
    pn[0] = 1; gq.push_back(0);
    cyc = 0;
    while (pb[0] < 100 && cyc < 3000) begin @(negedge clock); cyc++; end
    chk("proto_reach_feed", 32'(pb[0] >= 100), 1);
    force_ev = 1'b1;
    @(negedge clock);
    chk("proto_eor_low", 32'(eng_out_ready), 0);
    chk("proto_not_yet", 32'(proto_err), 0);
    force_ev = 1'b0;
    @(negedge clock);
    chk("proto_set", 32'(proto_err), 1);
    wait_done(7, 5000, "proto_frame_done");
    chk("proto_sticky", 32'(proto_err), 1);

    // Reset mid-frame at in_cnt == 400.
    pn[2] = 1; gq.push_back(2);
    cyc = 0;
    while (pb[2] < 400 && cyc < 3000) begin @(negedge clock); cyc++; end
    chk("mid_in_cnt", 32'(dut.in_cnt), 400);
    #1 reset_n = 1'b0;
    #1 check_reset_outputs("midrst");
    repeat (3) @(negedge clock);
    gq.push_back(2);
    reset_n = 1'b1;
    wait_done(1, 5000, "post_reset_done");
    chk("post_reset_sb_empty", 32'(exp_ch.size()), 0);
    chk("post_reset_gq_empty", 32'(gq.size()), 0);
    chk("post_reset_proto", 32'(proto_err), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
